mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage LoongArch core, between EXE and WB. It registers the EXE result and completes loads using the synchronous data SRAM read data. It transmits `{regW, regWAddr, regWData, pc}` to WB over the valid/allowin handshake and publishes a forwarding bus to ID.

## Interface

Parameters:
- EXE_TO_MEM_WD, 74, width of exe_to_mem_bus
- MEM_TO_WB_WD, 70, width of mem_to_wb_bus
- MEM_TO_ID_WD, 39, width of mem_to_id_bus

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_allowin  out  1  MEM can accept an instruction this cycle
- exe_to_mem_valid  in  1  EXE presents a valid instruction
- exe_to_mem_bus  in  74  {res_from_mem[73], ld_sign[72], ld_size[71:70], regW[69], regWAddr[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read word for the load now in MEM (request issued by EXE one cycle earlier)
- wb_allowin  in  1  WB can accept
- mem_to_wb_valid  out  1  MEM presents a valid instruction to WB
- mem_to_wb_bus  out  70  {regW[69], regWAddr[68:64], regWData[63:32], pc[31:0]}
- mem_to_id_bus  out  39  {mem_valid[38], regW[37], regWAddr[36:32], regWData[31:0]}

## Operation

- Stage state: `mem_valid` (1 bit) and `mem_data` (74 bits).
- `mem_ready_go` = 1. The SRAM is synchronous, so there is no wait state.
- `mem_allowin` = ~mem_valid | (mem_ready_go & wb_allowin).
- `mem_to_wb_valid` = mem_valid & mem_ready_go.
- Valid register update:
  - On reset, mem_valid = 0.
  - Otherwise, when mem_allowin is 1, mem_valid <= exe_to_mem_valid.
  - When mem_allowin is 0, mem_valid holds.
- Data register update:
  - mem_data <= exe_to_mem_bus only when mem_allowin & exe_to_mem_valid.
  - On reset, mem_data = 0.
  - When a bubble is accepted, the old mem_data is kept; it is don't-care because mem_valid = 0.
- Load result when res_from_mem = 1, with `a` = alu_result[1:0]:
  - ld_size 00 (byte): byte = rdata[8a+7 : 8a]. Sign-extend if ld_sign = 1, otherwise zero-extend.
  - ld_size 01 (half): half = rdata[31:16] if a[1] = 1, else rdata[15:0]. Sign- or zero-extend per ld_sign. a[0] is ignored; EXE guarantees alignment.
  - ld_size 10 (word): rdata unchanged.
  - ld_size 11: reserved; output rdata unchanged.
- Non-load (res_from_mem = 0): regWData = alu_result. ld_sign and ld_size are ignored.
- mem_to_wb_bus = {regW, regWAddr, regWData, pc} taken from mem_data plus the computed regWData.
- mem_to_id_bus = {mem_valid, regW, regWAddr, regWData}.
  - ID treats a match as valid only when mem_valid & regW & (regWAddr != 0).
  - MEM forwards regW unmasked, including for regWAddr = 0.
- regW is not gated by mem_valid on mem_to_wb_bus; WB gates it with its own valid.

## Timing

- Latency: one cycle EXE→MEM register. Output is combinational from the register and data_sram_rdata.
- data_sram_rdata must be stable for the whole cycle in which its load sits in MEM.
- Stall (mem_valid = 1, wb_allowin = 0):
  - mem_valid and mem_data hold.
  - mem_allowin = 0.
  - EXE must hold its SRAM request so rdata stays valid.
- Simultaneous drain and fill (wb_allowin = 1, exe_to_mem_valid = 1): the new instruction is captured in the same edge the old one leaves. Full throughput is one instruction per cycle.
- Empty stage: mem_allowin = 1 regardless of wb_allowin.
- Reset mid-operation: the next edge with resetn = 0 clears mem_valid. The in-flight instruction is dropped and no handshake is completed.
- Reset values of outputs:
  - mem_allowin = 1
  - mem_to_wb_valid = 0
  - mem_to_id_bus[38] = 0
  - remaining bus bits = 0, derived from mem_data = 0 and regWData = alu_result = 0

## Test plan

- **Reset:** hold resetn = 0 for 2 cycles → mem_allowin = 1, mem_to_wb_valid = 0, mem_to_id_bus = 0.
- **ALU pass-through:** exe valid with bus {0,0,00,1,5'd3,32'h1234_5678,32'h1C00_0010} and wb_allowin = 1 → next cycle mem_to_wb_bus = {1,3,32'h1234_5678,32'h1C00_0010}, mem_to_wb_valid = 1, mem_to_id_bus[38] = 1.
- **Byte loads:** rdata = 32'h80FF_7F01 with alu_result[1:0] = 3:
  - ld.b → regWData = 32'hFFFF_FF80.
  - ld.bu → 32'h0000_0080.
  - addr 1 with ld.b → 32'h0000_007F.
- **Half loads:** rdata = 32'h8001_7FFE:
  - ld.h at addr 2 → 32'hFFFF_8001.
  - ld.hu at addr 2 → 32'h0000_8001.
  - ld.h at addr 0 → 32'h0000_7FFE.
  - ld.w → 32'h8001_7FFE.
- **Stall:** wb_allowin = 0 for 3 cycles while mem_valid = 1 and EXE offers a new instruction → mem_allowin = 0, mem_data and outputs unchanged. When wb_allowin rises, the new instruction appears the following cycle with no loss or duplicate.
- **Back-to-back and reset mid-stream:** 4 consecutive valid instructions → 4 consecutive mem_to_wb_valid cycles in order. Asserting resetn = 0 while mem_valid = 1 → mem_to_wb_valid = 0 on the next cycle.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage of the five-stage LoongArch
//                core (EXE -> MEM -> WB). Registers the EXE result, completes
//                loads from the synchronous data SRAM read word, hands
//                {regW, regWAddr, regWData, pc} to WB over valid/allowin and
//                publishes a forwarding bus to ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int EXE_TO_MEM_WD = 74,
    parameter int MEM_TO_WB_WD  = 70,
    parameter int MEM_TO_ID_WD  = 39
) (
    input  logic                     clk,
    input  logic                     resetn,
    // EXE -> MEM handshake
    output logic                     mem_allowin,
    input  logic                     exe_to_mem_valid,
    input  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
    // synchronous data SRAM read word for the load currently in MEM
    input  logic [31:0]              data_sram_rdata,
    // MEM -> WB handshake
    input  logic                     wb_allowin,
    output logic                     mem_to_wb_valid,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    // forwarding path back to ID
    output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus
);

    // ------------------------------------------------------------------
    // Load size encodings carried in ld_size
    // ------------------------------------------------------------------
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic                     r_mem_valid;
    logic [EXE_TO_MEM_WD-1:0] r_mem_data;

    // Handshake wires
    logic                     w_mem_ready_go;
    logic                     w_accept;

    // Fields unpacked from the stage register
    logic                     w_res_from_mem;
    logic                     w_ld_sign;
    logic [1:0]               w_ld_size;
    logic                     w_regw;
    logic [4:0]               w_regw_addr;
    logic [31:0]              w_alu_result;
    logic [31:0]              w_pc;
    logic [1:0]               w_byte_off;

    // Load-alignment datapath
    logic [7:0]               w_ld_byte;
    logic [15:0]              w_ld_half;
    logic [31:0]              w_ld_result;
    logic [31:0]              w_regw_data;

    // ------------------------------------------------------------------
    // Handshake. The SRAM answers in the cycle the load sits here, so the
    // stage never needs a wait state.
    // ------------------------------------------------------------------
    assign w_mem_ready_go  = 1'b1;
    assign mem_allowin     = ~r_mem_valid | (w_mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = r_mem_valid & w_mem_ready_go;
    assign w_accept        = mem_allowin & exe_to_mem_valid;

    // Valid bit: refilled (possibly with a bubble) whenever the stage can accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            r_mem_valid <= exe_to_mem_valid;
        end
    end

    // Payload: captured only for real instructions; bubbles leave stale data
    // behind, which is harmless because the valid bit is low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_data <= '0;
        end else if (w_accept) begin
            r_mem_data <= exe_to_mem_bus;
        end
    end

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    assign w_res_from_mem = r_mem_data[73];
    assign w_ld_sign      = r_mem_data[72];
    assign w_ld_size      = r_mem_data[71:70];
    assign w_regw         = r_mem_data[69];
    assign w_regw_addr    = r_mem_data[68:64];
    assign w_alu_result   = r_mem_data[63:32];
    assign w_pc           = r_mem_data[31:0];
    assign w_byte_off     = w_alu_result[1:0];

    // Pick the addressed byte/halfword and extend it to a full word. The
    // halfword select uses only the upper offset bit because EXE guarantees
    // halfword alignment; the reserved size code passes the word through.
    always_comb begin
        w_ld_byte   = 8'h00;
        w_ld_half   = 16'h0000;
        w_ld_result = data_sram_rdata;

        case (w_byte_off)
            2'd0:    w_ld_byte = data_sram_rdata[7:0];
            2'd1:    w_ld_byte = data_sram_rdata[15:8];
            2'd2:    w_ld_byte = data_sram_rdata[23:16];
            default: w_ld_byte = data_sram_rdata[31:24];
        endcase

        w_ld_half = w_byte_off[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

        case (w_ld_size)
            c_SIZE_BYTE: w_ld_result = {{24{w_ld_sign & w_ld_byte[7]}}, w_ld_byte};
            c_SIZE_HALF: w_ld_result = {{16{w_ld_sign & w_ld_half[15]}}, w_ld_half};
            c_SIZE_WORD: w_ld_result = data_sram_rdata;
            default:     w_ld_result = data_sram_rdata;
        endcase
    end

    assign w_regw_data = w_res_from_mem ? w_ld_result : w_alu_result;

    // ------------------------------------------------------------------
    // Output buses. regW is left ungated here: WB qualifies it with its own
    // valid, and ID qualifies forwarding with the mem_valid bit carried in
    // the forwarding bus.
    // ------------------------------------------------------------------
    assign mem_to_wb_bus = {w_regw, w_regw_addr, w_regw_data, w_pc};
    assign mem_to_id_bus = {r_mem_valid, w_regw, w_regw_addr, w_regw_data};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking testbench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    logic [73:0] exe_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;

    int n_checks;
    int n_fail;

    mem_stage #(
        .EXE_TO_MEM_WD (74),
        .MEM_TO_WB_WD  (70),
        .MEM_TO_ID_WD  (39)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_allowin      (mem_allowin),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [73:0] mk_bus(input logic rfm, input logic sgn,
                                           input logic [1:0] size, input logic regw,
                                           input logic [4:0] addr, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {rfm, sgn, size, regw, addr, alu, pc};
    endfunction

    task automatic test_reset();
        resetn           = 1'b0;
        wb_allowin       = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1C00_0000);
        data_sram_rdata  = 32'hFFFF_FFFF;
        tick();
        tick();
        exe_to_mem_valid = 1'b0;
        n_checks++;
        if (mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL reset_allowin: got %b expected 1", mem_allowin);
        end
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_id_bus !== 39'h0) begin
            n_fail++; $display("FAIL reset_id_bus: got %h expected 0", mem_to_id_bus);
        end
        n_checks++;
        if (mem_to_wb_bus !== 70'h0) begin
            n_fail++; $display("FAIL reset_wb_bus: got %h expected 0", mem_to_wb_bus);
        end
        resetn = 1'b1;
        tick();
        // empty stage accepts even when WB is blocked
        n_checks++;
        if (mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL empty_allowin: got %b expected 1", mem_allowin);
        end
    endtask

    task automatic test_alu_pass();
        logic [69:0] exp_wb;
        logic [38:0] exp_id;
        exp_wb = {1'b1, 5'd3, 32'h1234_5678, 32'h1C00_0010};
        exp_id = {1'b1, 1'b1, 5'd3, 32'h1234_5678};
        wb_allowin       = 1'b1;
        data_sram_rdata  = 32'hA5A5_A5A5;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 32'h1234_5678, 32'h1C00_0010);
        tick();
        exe_to_mem_valid = 1'b0;
        n_checks++;
        if (mem_to_wb_bus !== exp_wb) begin
            n_fail++; $display("FAIL alu_wb_bus: got %h expected %h", mem_to_wb_bus, exp_wb);
        end
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL alu_wb_valid: got %b expected 1", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_id_bus !== exp_id) begin
            n_fail++; $display("FAIL alu_id_bus: got %h expected %h", mem_to_id_bus, exp_id);
        end
        tick();
        n_checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus[38] !== 1'b0) begin
            n_fail++; $display("FAIL alu_drain: got valid %b id38 %b expected 0 0",
                               mem_to_wb_valid, mem_to_id_bus[38]);
        end
    endtask

    // each load goes in, is checked in MEM, and drains on the next edge
    task automatic test_loads();
        logic [1:0]  sz  [11];
        logic        sg  [11];
        logic [31:0] adr [11];
        logic [31:0] rd  [11];
        logic [31:0] exp [11];
        // byte loads on 80FF_7F01
        sz[0]  = 2'b00; sg[0]  = 1'b1; adr[0]  = 32'h0000_1003; rd[0]  = 32'h80FF_7F01; exp[0]  = 32'hFFFF_FF80;
        sz[1]  = 2'b00; sg[1]  = 1'b0; adr[1]  = 32'h0000_1003; rd[1]  = 32'h80FF_7F01; exp[1]  = 32'h0000_0080;
        sz[2]  = 2'b00; sg[2]  = 1'b1; adr[2]  = 32'h0000_1001; rd[2]  = 32'h80FF_7F01; exp[2]  = 32'h0000_007F;
        sz[3]  = 2'b00; sg[3]  = 1'b1; adr[3]  = 32'h0000_1002; rd[3]  = 32'h80FF_7F01; exp[3]  = 32'hFFFF_FFFF;
        sz[4]  = 2'b00; sg[4]  = 1'b0; adr[4]  = 32'h0000_1000; rd[4]  = 32'h80FF_7F01; exp[4]  = 32'h0000_0001;
        // half / word loads on 8001_7FFE
        sz[5]  = 2'b01; sg[5]  = 1'b1; adr[5]  = 32'h0000_2002; rd[5]  = 32'h8001_7FFE; exp[5]  = 32'hFFFF_8001;
        sz[6]  = 2'b01; sg[6]  = 1'b0; adr[6]  = 32'h0000_2002; rd[6]  = 32'h8001_7FFE; exp[6]  = 32'h0000_8001;
        sz[7]  = 2'b01; sg[7]  = 1'b1; adr[7]  = 32'h0000_2000; rd[7]  = 32'h8001_7FFE; exp[7]  = 32'h0000_7FFE;
        sz[8]  = 2'b10; sg[8]  = 1'b1; adr[8]  = 32'h0000_2000; rd[8]  = 32'h8001_7FFE; exp[8]  = 32'h8001_7FFE;
        sz[9]  = 2'b11; sg[9]  = 1'b1; adr[9]  = 32'h0000_2001; rd[9]  = 32'h8001_7FFE; exp[9]  = 32'h8001_7FFE;
        // signed half at 0 with negative low half
        sz[10] = 2'b01; sg[10] = 1'b1; adr[10] = 32'h0000_2000; rd[10] = 32'h0001_8000; exp[10] = 32'hFFFF_8000;
        wb_allowin = 1'b1;
        for (int i = 0; i < 11; i++) begin
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus   = mk_bus(1'b1, sg[i], sz[i], 1'b1, 5'd9, adr[i], 32'h1C00_0100 + 32'(i * 4));
            tick();
            exe_to_mem_valid = 1'b0;
            data_sram_rdata  = rd[i];
            #1;
            n_checks++;
            if (mem_to_wb_bus[63:32] !== exp[i] || mem_to_wb_valid !== 1'b1) begin
                n_fail++; $display("FAIL load_%0d: got data %h valid %b expected %h 1",
                                   i, mem_to_wb_bus[63:32], mem_to_wb_valid, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [73:0] bus_a;
        logic [73:0] bus_b;
        logic [69:0] exp_a;
        logic [69:0] exp_b;
        bus_a = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'd4, 32'h0000_AAAA, 32'h1C00_0200);
        bus_b = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'h0000_BBBB, 32'h1C00_0204);
        exp_a = {1'b1, 5'd4, 32'h0000_AAAA, 32'h1C00_0200};
        exp_b = {1'b1, 5'd5, 32'h0000_BBBB, 32'h1C00_0204};
        wb_allowin       = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = bus_a;
        tick();
        wb_allowin       = 1'b0;
        exe_to_mem_bus   = bus_b;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp_a) begin
                n_fail++; $display("FAIL stall_cycle_%0d: got allowin %b valid %b bus %h expected 0 1 %h",
                                   c, mem_allowin, mem_to_wb_valid, mem_to_wb_bus, exp_a);
            end
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        n_checks++;
        if (mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_allowin: got %b expected 1", mem_allowin);
        end
        tick();
        exe_to_mem_valid = 1'b0;
        n_checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp_b) begin
            n_fail++; $display("FAIL stall_next: got valid %b bus %h expected 1 %h",
                               mem_to_wb_valid, mem_to_wb_bus, exp_b);
        end
        tick();
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_dup: got valid %b expected 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        wb_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc               = 32'h1C00_0300 + 32'(i * 4);
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus   = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'(10 + i), 32'(100 + i), pc);
            tick();
            n_checks++;
            if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[31:0] !== pc
                || mem_to_wb_bus[63:32] !== 32'(100 + i)) begin
                n_fail++; $display("FAIL b2b_%0d: got valid %b pc %h data %h expected 1 %h %h",
                                   i, mem_to_wb_valid, mem_to_wb_bus[31:0], mem_to_wb_bus[63:32],
                                   pc, 32'(100 + i));
            end
        end
        exe_to_mem_valid = 1'b0;
        tick();
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got valid %b expected 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_reset_midstream();
        wb_allowin       = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(1'b0, 1'b0, 2'b00, 1'b1, 5'd12, 32'h0000_CCCC, 32'h1C00_0400);
        tick();
        exe_to_mem_valid = 1'b0;
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got valid %b expected 1", mem_to_wb_valid);
        end
        resetn = 1'b0;
        tick();
        n_checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus !== 39'h0 || mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL midrst_post: got valid %b id %h allowin %b expected 0 0 1",
                               mem_to_wb_valid, mem_to_id_bus, mem_allowin);
        end
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_pass();
        test_loads();
        test_stall();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
